// File: rtl/ikbd_mouse_quad.sv
// Turns IKBD mouse delta reports into paced quadrature steps.
// Signed per-axis accumulators drain one gray step per axis per tick.
module ikbd_mouse_quad #(
    parameter int STEP_DIV = 100,
    parameter int ACC_W    = 10
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       strobe,
    input  logic [7:0] dx,
    input  logic [7:0] dy,
    input  logic [1:0] btn_in,
    output logic [3:0] quad,
    output logic [1:0] buttons,
    output logic       idle
);
    localparam int SW = ACC_W + 2;
    localparam logic signed [SW-1:0] AMAX = SW'((2 ** (ACC_W - 1)) - 1);
    localparam logic [15:0] TMAX = 16'(STEP_DIV - 1);

    logic                    en_q;
    logic [15:0]             timer_q;
    logic signed [ACC_W-1:0] ax_q, ay_q, ax_d, ay_d;
    logic [1:0]              px_q, py_q, px_d, py_d;
    logic [1:0]              btn_q;
    logic                    idle_q;
    logic                    tick;
    logic signed [1:0]       sx, sy;

    function automatic logic signed [1:0] dir(input logic signed [ACC_W-1:0] a);
        logic signed [1:0] r;
        r = 2'sb00;
        if (a > 0) r = 2'sb01;
        else if (a < 0) r = 2'sb11;
        return r;
    endfunction

    // Wide intermediate so the clamp sees the true sum, never a wrapped one.
    function automatic logic signed [ACC_W-1:0] sum_sat(
        input logic signed [ACC_W-1:0] a,
        input logic [7:0]              d,
        input logic signed [1:0]       s,
        input logic                    take
    );
        logic signed [SW-1:0] t;
        t = $signed({{2{a[ACC_W-1]}}, a}) - $signed({{(SW-2){s[1]}}, s});
        if (take) t = t + $signed({{(SW-8){d[7]}}, d});
        if (t > AMAX) t = AMAX;
        else if (t < -AMAX) t = -AMAX;
        return t[ACC_W-1:0];
    endfunction

    // Phase is {A,B}; forward 00->10->11->01, backward is the inverse.
    function automatic logic [1:0] step(input logic [1:0] p, input logic signed [1:0] s);
        logic [1:0] r;
        r = p;
        unique case (1'b1)
            (s == 2'sb01): r = {~p[0], p[1]};
            (s == 2'sb11): r = {p[0], ~p[1]};
            default:       r = p;
        endcase
        return r;
    endfunction

    always_comb begin
        tick = (timer_q == TMAX);
        sx   = tick ? dir(ax_q) : 2'sb00;
        sy   = tick ? dir(ay_q) : 2'sb00;
        ax_d = sum_sat(ax_q, dx, sx, strobe);
        ay_d = sum_sat(ay_q, dy, sy, strobe);
        px_d = step(px_q, sx);
        py_d = step(py_q, sy);
    end

    // en_q swallows the release edge so a coincident strobe is dropped.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            en_q    <= 1'b0;
            timer_q <= '0;
            ax_q    <= '0;
            ay_q    <= '0;
            px_q    <= 2'b00;
            py_q    <= 2'b00;
            btn_q   <= 2'b00;
            idle_q  <= 1'b1;
        end else if (!en_q) begin
            en_q <= 1'b1;
        end else begin
            timer_q <= tick ? 16'd0 : timer_q + 16'd1;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            px_q    <= px_d;
            py_q    <= py_d;
            if (strobe) btn_q <= btn_in;
            idle_q  <= (ax_d == '0) && (ay_d == '0);
        end
    end

    assign quad    = {py_q[0], py_q[1], px_q[1], px_q[0]};
    assign buttons = btn_q;
    assign idle    = idle_q;
endmodule
